// File: rtl/circ_buf_ptr_ctrl_pkg.sv
// Shared width helpers and parameter legality check for the circular-buffer pointer controller.
package circ_buf_ptr_ctrl_pkg;

  function automatic int unsigned ptr_width(input int unsigned columns);
    return $clog2(columns);
  endfunction

  function automatic int unsigned count_width(input int unsigned columns);
    return $clog2(columns + 1);
  endfunction

  function automatic bit params_legal(input int unsigned columns,
                                      input int unsigned par_write,
                                      input int unsigned par_read);
    return (columns >= 2) && (par_write >= 1) && (par_write <= columns) &&
           (par_read >= 1) && (par_read <= columns);
  endfunction

endpackage

// File: rtl/circ_buf_ptr_ctrl_ptr_wrap_adder.sv
// Combinational pointer + STEP modulo COLUMNS, using a one-bit-wider sum so
// non-power-of-2 depths wrap correctly.
module ptr_wrap_adder
  import circ_buf_ptr_ctrl_pkg::*;
#(
  parameter int unsigned COLUMNS = 32,
  parameter int unsigned STEP    = 4
) (
  input  logic [ptr_width(COLUMNS)-1:0] ptr,
  output logic [ptr_width(COLUMNS)-1:0] next
);

  localparam int unsigned PTR_W = ptr_width(COLUMNS);
  localparam int unsigned SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = {1'b0, ptr} + SUM_W'(STEP);
    if (sum >= SUM_W'(COLUMNS)) begin
      sum = sum - SUM_W'(COLUMNS);
    end
    next = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/circ_buf_ptr_ctrl.sv
// Read/write pointer and occupancy tracking for a circular buffer with
// multi-entry commits and consumes, plus sticky overflow/underflow flags.
module circ_buf_ptr_ctrl
  import circ_buf_ptr_ctrl_pkg::*;
#(
  parameter int unsigned COLUMNS   = 32,
  parameter int unsigned PAR_WRITE = 4,
  parameter int unsigned PAR_READ  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            updateWP,
  input  logic                            updateRP,
  output logic [ptr_width(COLUMNS)-1:0]   write_ptr_out,
  output logic [ptr_width(COLUMNS)-1:0]   read_ptr_out,
  output logic [count_width(COLUMNS)-1:0] count,
  output logic                            wr_accept,
  output logic                            rd_accept,
  output logic                            full,
  output logic                            empty,
  output logic                            overflow_err,
  output logic                            underflow_err
);

  localparam int unsigned PTR_W = ptr_width(COLUMNS);
  localparam int unsigned CNT_W = count_width(COLUMNS);

  localparam logic [CNT_W-1:0] FULL_THR  = CNT_W'(COLUMNS - PAR_WRITE);
  localparam logic [CNT_W-1:0] EMPTY_THR = CNT_W'(PAR_READ);
  localparam logic [CNT_W-1:0] WR_STEP   = CNT_W'(PAR_WRITE);
  localparam logic [CNT_W-1:0] RD_STEP   = CNT_W'(PAR_READ);

  if (!params_legal(COLUMNS, PAR_WRITE, PAR_READ)) begin : g_bad_params
    $error("circ_buf_ptr_ctrl: need COLUMNS>=2 and 1<=PAR_WRITE,PAR_READ<=COLUMNS");
  end

  logic [PTR_W-1:0] wp_next;
  logic [PTR_W-1:0] rp_next;
  logic [CNT_W-1:0] count_next;

  ptr_wrap_adder #(.COLUMNS(COLUMNS), .STEP(PAR_WRITE)) u_wr_adder (
    .ptr  (write_ptr_out),
    .next (wp_next)
  );

  ptr_wrap_adder #(.COLUMNS(COLUMNS), .STEP(PAR_READ)) u_rd_adder (
    .ptr  (read_ptr_out),
    .next (rp_next)
  );

  // Acceptance is judged on the registered count only; a same-cycle op never helps the other.
  always_comb begin
    full       = count > FULL_THR;
    empty      = count < EMPTY_THR;
    wr_accept  = updateWP & ~full & ~clear;
    rd_accept  = updateRP & ~empty & ~clear;
    count_next = count;
    if (wr_accept) count_next = count_next + WR_STEP;
    if (rd_accept) count_next = count_next - RD_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ptr_out <= '0;
      read_ptr_out  <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      write_ptr_out <= '0;
      read_ptr_out  <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_accept) write_ptr_out <= wp_next;
      if (rd_accept) read_ptr_out  <= rp_next;
      count <= count_next;
      if (updateWP && full)  overflow_err  <= 1'b1;
      if (updateRP && empty) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_circ_buf_ptr_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic on two configurations
// (20/4/3 and 32/4/4) against an occupancy/pointer reference model.
module tb_circ_buf_ptr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Configuration A: COLUMNS=20, PAR_WRITE=4, PAR_READ=3
  logic       a_clear = 1'b0, a_uwp = 1'b0, a_urp = 1'b0;
  logic [4:0] a_wp, a_rp;
  logic [4:0] a_cnt;
  logic       a_wa, a_ra, a_full, a_empty, a_ov, a_un;

  // Configuration B: COLUMNS=32, PAR_WRITE=4, PAR_READ=4
  logic       b_clear = 1'b0, b_uwp = 1'b0, b_urp = 1'b0;
  logic [4:0] b_wp, b_rp;
  logic [5:0] b_cnt;
  logic       b_wa, b_ra, b_full, b_empty, b_ov, b_un;

  circ_buf_ptr_ctrl #(.COLUMNS(20), .PAR_WRITE(4), .PAR_READ(3)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .updateWP(a_uwp), .updateRP(a_urp),
    .write_ptr_out(a_wp), .read_ptr_out(a_rp), .count(a_cnt),
    .wr_accept(a_wa), .rd_accept(a_ra), .full(a_full), .empty(a_empty),
    .overflow_err(a_ov), .underflow_err(a_un)
  );

  circ_buf_ptr_ctrl #(.COLUMNS(32), .PAR_WRITE(4), .PAR_READ(4)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .updateWP(b_uwp), .updateRP(b_urp),
    .write_ptr_out(b_wp), .read_ptr_out(b_rp), .count(b_cnt),
    .wr_accept(b_wa), .rd_accept(b_ra), .full(b_full), .empty(b_empty),
    .overflow_err(b_ov), .underflow_err(b_un)
  );

  int vectors = 0;
  int miscompares = 0;

  int cols [2] = '{20, 32};
  int pw   [2] = '{4, 4};
  int pr   [2] = '{3, 4};

  // Reference model state per configuration
  int m_wp [2];
  int m_rp [2];
  int m_cnt[2];
  int m_ov [2];
  int m_un [2];

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wp[d] = 0; m_rp[d] = 0; m_cnt[d] = 0; m_ov[d] = 0; m_un[d] = 0;
    end
  endtask

  task automatic drive(input int d, input logic w, input logic r, input logic c);
    if (d == 0) begin a_uwp = w; a_urp = r; a_clear = c; end
    else        begin b_uwp = w; b_urp = r; b_clear = c; end
  endtask

  task automatic read_out(input int d, output int wp, output int rp, output int cnt,
                          output int wa, output int ra, output int fu, output int em,
                          output int ov, output int un);
    if (d == 0) begin
      wp = int'(a_wp); rp = int'(a_rp); cnt = int'(a_cnt); wa = int'(a_wa); ra = int'(a_ra);
      fu = int'(a_full); em = int'(a_empty); ov = int'(a_ov); un = int'(a_un);
    end else begin
      wp = int'(b_wp); rp = int'(b_rp); cnt = int'(b_cnt); wa = int'(b_wa); ra = int'(b_ra);
      fu = int'(b_full); em = int'(b_empty); ov = int'(b_ov); un = int'(b_un);
    end
  endtask

  task automatic check_state(input int d, input string tag);
    int wp, rp, cnt, wa, ra, fu, em, ov, un;
    read_out(d, wp, rp, cnt, wa, ra, fu, em, ov, un);
    check_val({tag, ".wp"}, wp, m_wp[d]);
    check_val({tag, ".rp"}, rp, m_rp[d]);
    check_val({tag, ".count"}, cnt, m_cnt[d]);
    check_val({tag, ".full"}, fu, (m_cnt[d] + pw[d] > cols[d]) ? 1 : 0);
    check_val({tag, ".empty"}, em, (m_cnt[d] < pr[d]) ? 1 : 0);
    check_val({tag, ".ovf"}, ov, m_ov[d]);
    check_val({tag, ".unf"}, un, m_un[d]);
  endtask

  // One clock of traffic: check same-cycle accepts, advance the model, check state after the edge.
  task automatic cycle(input int d, input logic w, input logic r, input logic c, input string tag);
    int wp, rp, cnt, wa, ra, fu, em, ov, un;
    bit room, avail, exp_wa, exp_ra;
    drive(d, w, r, c);
    #1;
    room   = (cols[d] - m_cnt[d]) >= pw[d];
    avail  = m_cnt[d] >= pr[d];
    exp_wa = w && room && !c;
    exp_ra = r && avail && !c;
    read_out(d, wp, rp, cnt, wa, ra, fu, em, ov, un);
    check_val({tag, ".wr_accept"}, wa, int'(exp_wa));
    check_val({tag, ".rd_accept"}, ra, int'(exp_ra));
    if (c) begin
      m_wp[d] = 0; m_rp[d] = 0; m_cnt[d] = 0; m_ov[d] = 0; m_un[d] = 0;
    end else begin
      if (exp_wa) begin m_wp[d] = (m_wp[d] + pw[d]) % cols[d]; m_cnt[d] += pw[d]; end
      if (exp_ra) begin m_rp[d] = (m_rp[d] + pr[d]) % cols[d]; m_cnt[d] -= pr[d]; end
      if (w && !room)  m_ov[d] = 1;
      if (r && !avail) m_un[d] = 1;
    end
    @(posedge clk);
    #1;
    check_state(d, tag);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #2;
    check_state(0, "reset_a");
    check_state(1, "reset_b");
    @(negedge clk);
    rst = 1'b0;

    // Fill A: pointer 4,8,12,16,0 and full after the fifth commit
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1'b1, 1'b0, 1'b0, "fill_a");
      check_val("fill_a.wp_const", int'(a_wp), ((i + 1) * 4) % 20);
    end
    check_val("fill_a.count20", int'(a_cnt), 20);
    check_val("fill_a.full", int'(a_full), 1);

    cycle(0, 1'b1, 1'b0, 1'b0, "overflow_a");
    check_val("overflow_a.flag", int'(a_ov), 1);

    // Full: only the read wins a simultaneous request
    cycle(0, 1'b1, 1'b1, 1'b0, "full_rw_a");
    check_val("full_rw_a.count17", int'(a_cnt), 17);
    check_val("full_rw_a.rp3", int'(a_rp), 3);

    for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b1, 1'b0, "drain_a");
    check_val("drain_a.count8", int'(a_cnt), 8);
    cycle(0, 1'b1, 1'b1, 1'b0, "both_a");
    check_val("both_a.count9", int'(a_cnt), 9);

    cycle(0, 1'b0, 1'b0, 1'b1, "clear_a");
    cycle(0, 1'b0, 1'b1, 1'b0, "underflow_a");
    check_val("underflow_a.flag", int'(a_un), 1);
    cycle(0, 1'b1, 1'b0, 1'b1, "clear_wr_a");

    // Async reset mid-cycle at count 12, with a write request pending
    for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0, 1'b0, "pre_rst_a");
    check_val("pre_rst_a.count12", int'(a_cnt), 12);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state(0, "async_rst_a");
    check_state(1, "async_rst_b");
    @(negedge clk);
    rst = 1'b0;
    cycle(0, 1'b1, 1'b0, 1'b0, "post_rst_a");
    drive(0, 1'b0, 1'b0, 1'b0);

    // Power-of-2 wrap on B
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1'b1, 1'b0, 1'b0, "fill_b");
      check_val("fill_b.wp_const", int'(b_wp), ((i + 1) * 4) % 32);
    end
    check_val("fill_b.full", int'(b_full), 1);
    drive(1, 1'b0, 1'b0, 1'b0);

    // Random traffic, biased so both full and empty regions get visited
    for (int n = 0; n < 600; n++) begin
      int d;
      logic w, r, c;
      d = n % 2;
      w = ($urandom_range(99) < ((n / 100) % 2 == 0 ? 70 : 35));
      r = ($urandom_range(99) < ((n / 100) % 2 == 0 ? 35 : 70));
      c = ($urandom_range(99) < 3);
      cycle(d, w, r, c, d == 0 ? "rand_a" : "rand_b");
      drive(d, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/circ_buf_ptr_ctrl.md
CIRC_BUF_PTR_CTRL -- requirements
Module: circ_buf_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter COLUMNS, default 32, meaning the circular buffer depth in entries (>= 2).
REQ-002 The block SHALL have parameter PAR_WRITE, default 4, meaning the entries committed per accepted write (1..COLUMNS).
REQ-003 The block SHALL have parameter PAR_READ, default 4, meaning the entries consumed per accepted read (1..COLUMNS).
REQ-004 Port list, one per entry:
- clk  input  1  the single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush.
- updateWP  input  1  write-commit request.
- updateRP  input  1  read-consume request.
- write_ptr_out  output  $clog2(COLUMNS)  next write slot.
- read_ptr_out  output  $clog2(COLUMNS)  next read slot.
- count  output  $clog2(COLUMNS+1)  occupied entries.
- wr_accept  output  1  updateWP honoured this cycle.
- rd_accept  output  1  updateRP honoured this cycle.
- full  output  1  fewer than PAR_WRITE free entries.
- empty  output  1  fewer than PAR_READ occupied entries.
- overflow_err  output  1  sticky rejected-write flag.
- underflow_err  output  1  sticky rejected-read flag.

Function
REQ-005 full SHALL equal (count > COLUMNS-PAR_WRITE) and empty SHALL equal (count < PAR_READ), both decoded combinationally from the registered count.
REQ-006 wr_accept SHALL equal updateWP & ~full & ~clear, and rd_accept SHALL equal updateRP & ~empty & ~clear, both combinational in the same cycle.
REQ-007 Acceptance SHALL be judged only on the current count; a same-cycle read SHALL NOT make room for a write, and a same-cycle write SHALL NOT supply data for a read.
REQ-008 On wr_accept, write_ptr_out SHALL advance by PAR_WRITE modulo COLUMNS at the next edge.
REQ-009 The modulo in REQ-008 SHALL be computed with a sum one bit wider than the pointer, subtracting COLUMNS when the sum >= COLUMNS, so non-power-of-2 COLUMNS wrap correctly.
REQ-010 On rd_accept, read_ptr_out SHALL advance by PAR_READ modulo COLUMNS using the same wrap rule.
REQ-011 count SHALL update by (+PAR_WRITE if wr_accept) and (-PAR_READ if rd_accept); with both asserted it SHALL change by PAR_WRITE-PAR_READ in one cycle, never passing through an intermediate value.
REQ-012 count SHALL always lie in 0..COLUMNS; pointers SHALL always lie in 0..COLUMNS-1.
REQ-013 updateWP while full (and clear low) SHALL set overflow_err at the next edge, leaving pointers and count unchanged.
REQ-014 updateRP while empty (and clear low) SHALL set underflow_err at the next edge, leaving pointers and count unchanged.
REQ-015 Error flags SHALL stay set until clear or rst.
REQ-016 clear SHALL take priority over updateWP and updateRP, zeroing both pointers, count and both error flags at the next edge.
REQ-017 State changes SHALL occur only on the rising edge of clk, except as stated under Reset.

Reset
REQ-018 rst high SHALL immediately and asynchronously force write_ptr_out=0, read_ptr_out=0, count=0, overflow_err=0 and underflow_err=0, giving empty=1 and full=(PAR_WRITE>COLUMNS-0)=0.
REQ-019 rst asserted mid-operation SHALL discard any in-flight request, and the first edge after rst deasserts SHALL evaluate requests against the reset state.

Structure
REQ-020 A shared package SHALL hold the pointer-width and count-width helper constants plus an elaboration check enforcing 1 <= PAR_WRITE, PAR_READ <= COLUMNS.
REQ-021 One sub-module, ptr_wrap_adder (parameters COLUMNS and STEP; combinational pointer+STEP modulo COLUMNS), SHALL be instantiated once for the write side and once for the read side.

Verification (COLUMNS=20, PAR_WRITE=4, PAR_READ=3 unless stated)
REQ-022 Five consecutive updateWP from reset -> write_ptr_out 4,8,12,16,0, count reaches 20, full=1 after the fifth write, wr_accept high on all five.
REQ-023 Sixth updateWP while full -> wr_accept=0, overflow_err=1 next edge, pointers and count unchanged.
REQ-024 From count=20, simultaneous updateWP and updateRP -> only rd_accept=1; count 17 and read_ptr_out 3 next edge.
REQ-025 At count=8, simultaneous updateWP and updateRP -> both accepted; count 9, both pointers advance by their step.
REQ-026 updateRP from reset -> underflow_err=1; then clear together with updateWP -> all state zero and wr_accept=0.
REQ-027 rst asserted between clock edges at count=12 -> outputs zero before the next edge; repeat REQ-022 with COLUMNS=32, PAR_WRITE=PAR_READ=4 to confirm power-of-2 wrap.
